// File: rtl/seq_serializer.sv
// seq_serializer: parallel-to-serial converter that feeds a downstream
// sequence detector one bit at a time.
// A word is accepted on load_valid & load_ready and is then shifted out on w,
// one bit per shift_en cycle. One extra word can wait in a pending register,
// so consecutive words leave with no gap between them.
//
// Ports
//   clk         in   clock, all state changes on the rising edge
//   rst_n       in   asynchronous active-low reset
//   data_in     in   [WIDTH-1:0] parallel word
//   load_valid  in   data_in is valid this cycle
//   load_ready  out  word is accepted this cycle (== !pending_full)
//   shift_en    in   downstream samples w this cycle, advance one bit
//   w           out  current serial bit (0 when w_valid=0)
//   w_valid     out  w carries a real data bit
//   word_done   out  one-cycle pulse after the last bit of a word is consumed
module seq_serializer #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic             shift_en,
   output logic             w,
   output logic             w_valid,
   output logic             word_done
);

   localparam int unsigned CW      = $clog2(WIDTH) + 1;
   localparam int unsigned OUT_IDX = MSB_FIRST ? WIDTH - 1 : 0;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] pend_q, pend_d;
   logic             pend_full_q, pend_full_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             w_q, w_d;
   logic             done_q, done_d;

   logic             load_xfer;
   logic             last_bit;
   logic [WIDTH-1:0] shifted;

   // A free pending slot is the only condition for accepting a word.
   assign load_ready = !pend_full_q;
   assign load_xfer  = load_valid && !pend_full_q;
   assign last_bit   = (cnt_q == CW'(WIDTH - 1));

   // Shift one position toward the output end.
   always_comb begin
      if (MSB_FIRST) shifted = {shift_q[WIDTH-2:0], 1'b0};
      else           shifted = {1'b0, shift_q[WIDTH-1:1]};
   end

   // Next-state and output decode.
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      pend_d      = pend_q;
      pend_full_d = pend_full_q;
      cnt_d       = cnt_q;
      done_d      = 1'b0;

      case (state_q)
         IDLE: begin
            pend_full_d = 1'b0;
            if (load_xfer) begin
               shift_d = data_in;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end

         SHIFT: begin
            if (shift_en && last_bit) begin
               done_d = 1'b1;
               cnt_d  = '0;
               // pending_full blocks load_xfer, so these branches are exclusive
               if (pend_full_q) begin
                  shift_d     = pend_q;
                  pend_full_d = 1'b0;
               end else if (load_xfer) begin
                  shift_d = data_in;
               end else begin
                  shift_d = '0;
                  state_d = IDLE;
               end
            end else begin
               if (shift_en) begin
                  shift_d = shifted;
                  cnt_d   = cnt_q + CW'(1);
               end
               if (load_xfer) begin
                  pend_d      = data_in;
                  pend_full_d = 1'b1;
               end
            end
         end

         default: begin
            state_d     = IDLE;
            shift_d     = '0;
            cnt_d       = '0;
            pend_full_d = 1'b0;
         end
      endcase

      // Serial bit is registered from the next shift-register value.
      w_d = (state_d == SHIFT) ? shift_d[OUT_IDX] : 1'b0;
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         pend_q      <= '0;
         pend_full_q <= 1'b0;
         cnt_q       <= '0;
         w_q         <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         pend_q      <= pend_d;
         pend_full_q <= pend_full_d;
         cnt_q       <= cnt_d;
         w_q         <= w_d;
         done_q      <= done_d;
      end
   end

   assign w         = w_q;
   assign w_valid   = (state_q == SHIFT);
   assign word_done = done_q;

endmodule

// File: doc/seq_serializer.md
SEQ_SERIALIZER -- requirements
Module: seq_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the number of bits per word (legal range 2..16).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1, meaning: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port data_in, input, WIDTH bits: the parallel word offered for serialisation.
REQ-006 The block SHALL have port load_valid, input, 1 bit: data_in is valid this cycle.
REQ-007 The block SHALL have port load_ready, output, 1 bit: the block accepts data_in this cycle.
REQ-008 The block SHALL have port shift_en, input, 1 bit: the downstream detector samples w this cycle, so advance one bit.
REQ-009 The block SHALL have port w, output, 1 bit: the current serial bit for the downstream sequence detector.
REQ-010 The block SHALL have port w_valid, output, 1 bit: w carries a real data bit.
REQ-011 The block SHALL have port word_done, output, 1 bit: one-cycle pulse when the last bit of a word is consumed.

Function
REQ-012 The block SHALL contain a WIDTH-bit shift register, a bit counter sized ceil(log2(WIDTH))+1, a WIDTH-bit pending register, and a pending_full flag.
REQ-013 The FSM SHALL have exactly two states: IDLE (no word in shift register) and SHIFT (word in progress); any illegal encoding SHALL go to IDLE.
REQ-014 A load transfer SHALL occur on a rising edge where load_valid=1 and load_ready=1.
REQ-015 load_ready SHALL be combinational and equal to !pending_full.
REQ-016 In IDLE, an accepted word SHALL go directly into the shift register, with the counter at 0 and the state set to SHIFT; w_valid=1 with the first bit from the next cycle (1-cycle load latency).
REQ-017 w_valid SHALL be 1 if and only if the state is SHIFT; w SHALL equal shift-register bit WIDTH-1 (MSB_FIRST=1) or bit 0 (MSB_FIRST=0), and SHALL be 0 when w_valid=0.
REQ-018 In SHIFT with shift_en=1, the shift register SHALL shift one position toward the output end and the counter SHALL increment; with shift_en=0, the shift register, counter and w SHALL hold.
REQ-019 The last bit is consumed when the counter = WIDTH-1 and shift_en=1; on that edge, word_done SHALL be 1 in the following cycle only.
REQ-020 On last-bit consumption with pending_full=1, the pending word SHALL move into the shift register, the counter SHALL clear, pending_full SHALL clear, and the state SHALL stay SHIFT (zero-gap back-to-back words).
REQ-021 On last-bit consumption with pending_full=0 and a simultaneous load transfer, data_in SHALL bypass into the shift register and the state SHALL stay SHIFT.
REQ-022 On last-bit consumption with pending_full=0 and no load transfer, the state SHALL return to IDLE.
REQ-023 A load transfer in SHIFT, when not bypassed per REQ-021, SHALL write the pending register and set pending_full.
REQ-024 A load transfer and a pending-to-shift move on the same edge SHALL be impossible, since load_ready=0 whenever pending_full=1.
REQ-025 In IDLE, pending_full SHALL always be 0.
REQ-026 No data word SHALL ever be dropped or duplicated; serial output order SHALL equal acceptance order.

Reset
REQ-027 While rst_n=0, regardless of clk: state=IDLE, counter=0, shift and pending registers=0, pending_full=0, w=0, w_valid=0, word_done=0, load_ready=1.
REQ-028 Reset asserted mid-word SHALL discard both the in-flight and the pending word; after release, no bit from either SHALL appear on w.
REQ-029 Reset deassertion SHALL be the only reset event; the first load transfer is legal on the first rising edge after rst_n rises.

Verification
REQ-030 WIDTH=8, MSB_FIRST=1, shift_en=1 always: load 8'hA5 -> w = 1,0,1,0,0,1,0,1 over 8 cycles starting 1 cycle after the load; word_done pulses once; then IDLE.
REQ-031 MSB_FIRST=0: load 8'h0F, shift_en=1 -> w = 1,1,1,1,0,0,0,0.
REQ-032 Load 8'hFF, then load 8'h00 during bit 3 -> load_ready=0 until the switch; 16 contiguous w_valid cycles (eight 1s then eight 0s); word_done pulses twice.
REQ-033 Load 8'hC3; hold load_valid with 8'h3C so it is offered on the last-bit edge with pending empty -> bypass, no gap, sequence 11000011 00111100.
REQ-034 Load 8'hA5; shift_en=0 for 3 cycles after bit 2 -> w and the counter hold, no bit is lost, and the total sequence still equals A5.
REQ-035 Load 8'hAA plus a pending 8'h55; pull rst_n low at bit 4 -> all outputs go to reset values immediately (asynchronously), load_ready=1, and no A/5 bits appear after release.
